// File: rtl/rf_defs.sv
// Shared constants and helpers for the multi-port bypassed register file.
package rf_defs;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefNregs = 8;
  localparam int unsigned MaxNread = 4;

  // Ceiling log2, never below 1 so a select bus always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_mp_array.sv
// Register storage with two prioritised write ports and NREAD raw read muxes.
module rf_mp_array
  import rf_defs::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREGS = DefNregs,
  parameter int unsigned NREAD = 2,
  parameter int unsigned SELW  = clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we0_i,
  input  logic [SELW-1:0]        wsel0_i,
  input  logic [WIDTH-1:0]       wdata0_i,
  input  logic                   we1_i,
  input  logic [SELW-1:0]        wsel1_i,
  input  logic [WIDTH-1:0]       wdata1_i,
  input  logic [NREAD*SELW-1:0]  rsel_i,
  output logic [NREAD*WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // Next state: port 1 overrides port 0; selects >= NREGS match no entry and are dropped.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      if (we0_i && (wsel0_i == SELW'(r))) regs_d[r] = wdata0_i;
      if (we1_i && (wsel1_i == SELW'(r))) regs_d[r] = wdata1_i;
    end
  end

  // Storage update with synchronous clear; writes in a reset cycle are lost.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rst_i) begin
        regs_q[r] <= '0;
      end else begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Raw read muxes; an unmatched (out-of-range) select reads zero.
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (rsel_i[p*SELW +: SELW] == SELW'(r)) begin
          rdata_o[p*WIDTH +: WIDTH] = regs_q[r];
        end
      end
    end
  end

endmodule

// File: rtl/rf_bypass_mp.sv
// Multi-port register file with write-to-read bypass, range checks and optional registered read.
module rf_bypass_mp
  import rf_defs::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned NREGS     = DefNregs,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned SYNC_READ = 0,
  localparam int unsigned SELW     = clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*SELW-1:0]  readregsel,
  output logic [NREAD*WIDTH-1:0] readdata,
  input  logic                   write0,
  input  logic [SELW-1:0]        write0regsel,
  input  logic [WIDTH-1:0]       write0data,
  input  logic                   write1,
  input  logic [SELW-1:0]        write1regsel,
  input  logic [WIDTH-1:0]       write1data,
  output logic                   err
);

  logic [NREAD*WIDTH-1:0] raw_data;
  logic [NREAD*WIDTH-1:0] byp_data;
  logic [NREAD-1:0]       rd_oor;
  logic [SELW-1:0]        sel;

  rf_mp_array #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .NREAD (NREAD),
    .SELW  (SELW)
  ) u_array (
    .clk_i    (clk),
    .rst_i    (rst),
    .we0_i    (write0),
    .wsel0_i  (write0regsel),
    .wdata0_i (write0data),
    .we1_i    (write1),
    .wsel1_i  (write1regsel),
    .wdata1_i (write1data),
    .rsel_i   (readregsel),
    .rdata_o  (raw_data)
  );

  // Per-port bypass: range check first, then port 1, port 0, stored value; no bypass in reset.
  always_comb begin
    byp_data = '0;
    rd_oor   = '0;
    sel      = '0;
    for (int p = 0; p < NREAD; p++) begin
      sel = readregsel[p*SELW +: SELW];
      if (32'(sel) >= NREGS) begin
        rd_oor[p]                  = 1'b1;
        byp_data[p*WIDTH +: WIDTH] = '0;
      end else if (!rst && write1 && (sel == write1regsel)) begin
        byp_data[p*WIDTH +: WIDTH] = write1data;
      end else if (!rst && write0 && (sel == write0regsel)) begin
        byp_data[p*WIDTH +: WIDTH] = write0data;
      end else begin
        byp_data[p*WIDTH +: WIDTH] = raw_data[p*WIDTH +: WIDTH];
      end
    end
  end

  // Error flag: same-destination writes, out-of-range write or read selects; masked in reset.
  always_comb begin
    err = 1'b0;
    if (!rst) begin
      err = (write0 && write1 && (write0regsel == write1regsel)) ||
            (write0 && (32'(write0regsel) >= NREGS)) ||
            (write1 && (32'(write1regsel) >= NREGS)) ||
            (|rd_oor);
    end
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [NREAD*WIDTH-1:0] rd_q;
    logic [NREAD*WIDTH-1:0] rd_d;

    // Register the bypassed result so it reflects state after the current edge.
    always_comb begin
      rd_d = byp_data;
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign readdata = rd_q;
  end else begin : g_comb_read
    assign readdata = byp_data;
  end

endmodule
